// File: rtl/maverickOne_pkg.sv
// Core-wide architectural widths shared by the maverickOne front end.
package maverickOne_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
endpackage

// File: rtl/instr_mem_arbiter.sv
// Round-robin arbiter sharing the instruction-memory read port between
// instruction fetch and the LSU, with flush draining and a fetch stall counter.
module instr_mem_arbiter #(
  parameter int unsigned XLEN  = maverickOne_pkg::XLEN,
  parameter int unsigned ILEN  = maverickOne_pkg::ILEN,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             fetch_req_i,
  input  logic [XLEN-1:0]  fetch_addr_i,
  output logic             fetch_gnt_o,
  output logic [ILEN-1:0]  fetch_data_o,
  input  logic             lsu_req_i,
  input  logic [XLEN-1:0]  lsu_addr_i,
  output logic             lsu_gnt_o,
  output logic [ILEN-1:0]  lsu_data_o,
  input  logic             flush_i,
  output logic             mem_req_o,
  output logic [XLEN-1:0]  mem_addr_o,
  input  logic             mem_gnt_i,
  input  logic [ILEN-1:0]  mem_data_i,
  output logic [CNT_W-1:0] fetch_stall_cnt_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] LSU   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]       state, state_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q;
  logic             fetch_cand;
  logic             fetch_gnt, lsu_gnt;
  logic             stall;

  assign fetch_cand = fetch_req_i & ~flush_i;

  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state;
    addr_d    = addr_q;
    last_d    = last_q;
    fetch_gnt = 1'b0;
    lsu_gnt   = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie the side that was not served last wins.
        if (fetch_cand && (!lsu_req_i || last_q)) begin
          addr_d  = fetch_addr_i;
          state_d = FETCH;
        end else if (lsu_req_i) begin
          addr_d  = lsu_addr_i;
          state_d = LSU;
        end
      end
      FETCH: begin
        if (mem_gnt_i) begin
          fetch_gnt = ~flush_i;
          last_d    = 1'b0;
          state_d   = IDLE;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The memory still owes us a beat; swallow it before re-arbitrating.
        if (mem_gnt_i) begin
          last_d  = 1'b0;
          state_d = IDLE;
        end
      end
      LSU: begin
        if (mem_gnt_i) begin
          lsu_gnt = 1'b1;
          last_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A reset abandons the open transaction, so no grant escapes in that cycle.
  assign fetch_gnt_o  = fetch_gnt & ~srst_i;
  assign lsu_gnt_o    = lsu_gnt & ~srst_i;
  assign fetch_data_o = mem_data_i;
  assign lsu_data_o   = mem_data_i;
  assign mem_req_o    = (state != IDLE);
  assign mem_addr_o   = addr_q;

  assign stall = fetch_req_i & ~fetch_gnt_o & ~flush_i;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state  <= IDLE;
      addr_q <= '0;
      last_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      state  <= state_d;
      addr_q <= addr_d;
      last_q <= last_d;
      if (stall && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fetch_stall_cnt_o = cnt_q;

  // Requester protocol: hold request and address until granted (fetch may
  // also be released by a flush); reset releases both sides.
  a_lsu_hold: assert property (@(posedge clk_i)
    (!srst_i && lsu_req_i && !lsu_gnt_o) |=> (lsu_req_i || srst_i));
  a_fetch_hold: assert property (@(posedge clk_i)
    (!srst_i && fetch_req_i && !fetch_gnt_o && !flush_i) |=> (fetch_req_i || flush_i || srst_i));
  a_lsu_addr: assert property (@(posedge clk_i)
    (!srst_i && lsu_req_i && !lsu_gnt_o) |=> (!lsu_req_i || srst_i || $stable(lsu_addr_i)));
  a_fetch_addr: assert property (@(posedge clk_i)
    (!srst_i && fetch_req_i && !fetch_gnt_o && !flush_i) |=> (!fetch_req_i || srst_i || $stable(fetch_addr_i)));
  a_one_gnt: assert property (@(posedge clk_i) !(fetch_gnt_o && lsu_gnt_o));

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter: arbitration order, flush/drain,
// reset abandonment and stall-counter saturation (16-bit and 4-bit counters).
module tb_instr_mem_arbiter;
  localparam int unsigned XLEN = maverickOne_pkg::XLEN;
  localparam int unsigned ILEN = maverickOne_pkg::ILEN;

  logic            clk_i = 1'b0;
  logic            srst_i;
  logic            fetch_req_i, lsu_req_i, flush_i, mem_gnt_i;
  logic [XLEN-1:0] fetch_addr_i, lsu_addr_i;
  logic [ILEN-1:0] mem_data_i;

  logic            fetch_gnt_o, lsu_gnt_o, mem_req_o;
  logic [ILEN-1:0] fetch_data_o, lsu_data_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [15:0]     fetch_stall_cnt_o;

  logic            fetch_gnt4, lsu_gnt4, mem_req4;
  logic [ILEN-1:0] fetch_data4, lsu_data4;
  logic [XLEN-1:0] mem_addr4;
  logic [3:0]      cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  instr_mem_arbiter #(.CNT_W(16)) dut (
    .clk_i(clk_i), .srst_i(srst_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_gnt_o(fetch_gnt_o), .fetch_data_o(fetch_data_o),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_data_o(lsu_data_o),
    .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_data_i(mem_data_i),
    .fetch_stall_cnt_o(fetch_stall_cnt_o)
  );

  instr_mem_arbiter #(.CNT_W(4)) dut4 (
    .clk_i(clk_i), .srst_i(srst_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_gnt_o(fetch_gnt4), .fetch_data_o(fetch_data4),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i),
    .lsu_gnt_o(lsu_gnt4), .lsu_data_o(lsu_data4),
    .flush_i(flush_i), .mem_req_o(mem_req4), .mem_addr_o(mem_addr4),
    .mem_gnt_i(mem_gnt_i), .mem_data_i(mem_data_i),
    .fetch_stall_cnt_o(cnt4)
  );

  // Round-robin table, both sides requesting from reset with memory always granting.
  bit          rr_req [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  bit          rr_fg  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  bit          rr_lg  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] rr_addr[8] = '{32'h0, 32'h100, 32'h0, 32'h200, 32'h0, 32'h100, 32'h0, 32'h200};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    step();
    srst_i = 1'b1; fetch_req_i = 1'b0; lsu_req_i = 1'b0; flush_i = 1'b0; mem_gnt_i = 1'b0;
    step();
    srst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fetch_addr_i = '0; lsu_addr_i = '0; mem_data_i = '0;
    do_reset();
    #1;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_fetch_gnt", fetch_gnt_o, 0);
    check("rst_lsu_gnt", lsu_gnt_o, 0);
    check("rst_cnt", fetch_stall_cnt_o, 0);

    // Single fetch, memory grants two cycles after mem_req_o rises.
    step(); fetch_req_i = 1'b1; fetch_addr_i = 32'h1000; #1;
    check("f1_idle_req", mem_req_o, 0);
    step(); #1;
    check("f1_req", mem_req_o, 1);
    check("f1_addr", mem_addr_o, 32'h1000);
    check("f1_nognt", fetch_gnt_o, 0);
    step(); #1;
    check("f1_wait", fetch_gnt_o, 0);
    step(); mem_gnt_i = 1'b1; mem_data_i = 32'hCAFE_F00D; #1;
    check("f1_gnt", fetch_gnt_o, 1);
    check("f1_data", fetch_data_o, 32'hCAFE_F00D);
    check("f1_lsu_gnt", lsu_gnt_o, 0);
    check("f1_gnt_addr", mem_addr_o, 32'h1000);
    step(); fetch_req_i = 1'b0; mem_gnt_i = 1'b0; #1;
    check("f1_gnt_once", fetch_gnt_o, 0);
    check("f1_idle", mem_req_o, 0);
    check("f1_cnt", fetch_stall_cnt_o, 3);

    // Alternation from reset.
    do_reset();
    fetch_req_i = 1'b1; fetch_addr_i = 32'h100;
    lsu_req_i = 1'b1; lsu_addr_i = 32'h200; mem_gnt_i = 1'b1; mem_data_i = 32'h1234_5678;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      if (i == 6) fetch_req_i = 1'b0;
      #1;
      check($sformatf("rr%0d_req", i), mem_req_o, rr_req[i]);
      check($sformatf("rr%0d_fgnt", i), fetch_gnt_o, rr_fg[i]);
      check($sformatf("rr%0d_lgnt", i), lsu_gnt_o, rr_lg[i]);
      if (rr_req[i]) check($sformatf("rr%0d_addr", i), mem_addr_o, rr_addr[i]);
    end
    step(); lsu_req_i = 1'b0; mem_gnt_i = 1'b0; #1;
    check("rr_end_idle", mem_req_o, 0);

    // Flush during fetch: drain, then serve the waiting LSU.
    step(); fetch_req_i = 1'b1; fetch_addr_i = 32'h300; lsu_req_i = 1'b1; lsu_addr_i = 32'h400; #1;
    check("dr_idle", mem_req_o, 0);
    step(); #1;
    check("dr_fetch_addr", mem_addr_o, 32'h300);
    step(); flush_i = 1'b1; #1;
    check("dr_flush_nogn", fetch_gnt_o, 0);
    step(); flush_i = 1'b0; fetch_req_i = 1'b0; #1;
    check("dr_drain_req", mem_req_o, 1);
    check("dr_drain_addr", mem_addr_o, 32'h300);
    step(); #1;
    check("dr_drain_req2", mem_req_o, 1);
    step(); mem_gnt_i = 1'b1; mem_data_i = 32'hBAD0_BAD0; #1;
    check("dr_discard_f", fetch_gnt_o, 0);
    check("dr_discard_l", lsu_gnt_o, 0);
    step(); mem_gnt_i = 1'b0; #1;
    check("dr_back_idle", mem_req_o, 0);
    step(); mem_gnt_i = 1'b1; mem_data_i = 32'h0000_0400; #1;
    check("dr_lsu_gnt", lsu_gnt_o, 1);
    check("dr_lsu_addr", mem_addr_o, 32'h400);
    step(); lsu_req_i = 1'b0; mem_gnt_i = 1'b0; #1;
    check("dr_end_idle", mem_req_o, 0);

    // Flush coinciding with the memory grant in FETCH.
    step(); fetch_req_i = 1'b1; fetch_addr_i = 32'h500; #1;
    step(); flush_i = 1'b1; mem_gnt_i = 1'b1; #1;
    check("fg_nogrant", fetch_gnt_o, 0);
    check("fg_req", mem_req_o, 1);
    step(); flush_i = 1'b0; mem_gnt_i = 1'b0; fetch_req_i = 1'b0; #1;
    check("fg_idle", mem_req_o, 0);

    // Flush while the LSU owns the port.
    step(); lsu_req_i = 1'b1; lsu_addr_i = 32'h600; #1;
    step(); flush_i = 1'b1; #1;
    check("lf_wait", lsu_gnt_o, 0);
    check("lf_addr", mem_addr_o, 32'h600);
    step(); mem_gnt_i = 1'b1; mem_data_i = 32'h6666_0000; #1;
    check("lf_gnt", lsu_gnt_o, 1);
    check("lf_data", lsu_data_o, 32'h6666_0000);
    step(); lsu_req_i = 1'b0; flush_i = 1'b0; mem_gnt_i = 1'b0; #1;
    check("lf_idle", mem_req_o, 0);

    // Reset in the middle of a stalled LSU transaction.
    step(); lsu_req_i = 1'b1; lsu_addr_i = 32'h700; #1;
    step(); #1;
    check("rs_lsu_req", mem_req_o, 1);
    check("rs_lsu_addr", mem_addr_o, 32'h700);
    step(); srst_i = 1'b1; #1;
    check("rs_no_gnt", lsu_gnt_o, 0);
    step(); srst_i = 1'b0; lsu_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
    check("rs_mem_req", mem_req_o, 0);
    check("rs_mem_addr", mem_addr_o, 0);
    check("rs_lsu_gnt", lsu_gnt_o, 0);
    check("rs_fetch_gnt", fetch_gnt_o, 0);
    check("rs_cnt", fetch_stall_cnt_o, 0);

    // Fetch starved by a long LSU transaction: 4-bit counter saturates.
    step(); mem_gnt_i = 1'b0; lsu_req_i = 1'b1; lsu_addr_i = 32'h800; #1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin fetch_req_i = 1'b1; fetch_addr_i = 32'h900; end
      #1;
      if (k == 2)  check("sat_cnt4_k2", cnt4, 1);
      if (k == 16) check("sat_cnt4_k16", cnt4, 15);
      if (k == 20) begin
        check("sat_cnt4_k20", cnt4, 15);
        check("sat_cnt16_k20", fetch_stall_cnt_o, 19);
        check("sat_lsu_wait", lsu_gnt_o, 0);
      end
    end
    step(); mem_gnt_i = 1'b1; #1;
    check("sat_lsu_gnt", lsu_gnt_o, 1);
    step(); lsu_req_i = 1'b0; mem_gnt_i = 1'b0; #1;
    check("sat_idle", mem_req_o, 0);
    step(); mem_gnt_i = 1'b1; #1;
    check("sat_fetch_gnt", fetch_gnt_o, 1);
    check("sat_fetch_addr", mem_addr_o, 32'h900);
    step(); fetch_req_i = 1'b0; mem_gnt_i = 1'b0; #1;
    check("sat_cnt16_end", fetch_stall_cnt_o, 22);
    check("sat_cnt4_end", cnt4, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
